// File: rtl/cal_field_counter_if.sv
// Bus bundle for one calendar-field counter: control strobes, buttons,
// runtime bound and the counter outputs.
interface cal_field_counter_if #(
  parameter int WIDTH = 5
);
  logic             tick;
  logic             inc_btn;
  logic             dec_btn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] value;
  logic             carry;
  logic             borrow;

  modport master (
    output tick, inc_btn, dec_btn, load, load_val, limit,
    input  value, carry, borrow
  );

  modport slave (
    input  tick, inc_btn, dec_btn, load, load_val, limit,
    output value, carry, borrow
  );
endinterface

// File: rtl/cal_field_counter.sv
// Calendar-field counter with runtime upper bound: timer tick advance,
// debounced-by-sync inc/dec buttons with hold-to-repeat, direct load,
// and carry/borrow pulses for chaining the next field.
module cal_field_counter #(
  parameter int WIDTH         = 5,
  parameter int MIN_VAL       = 0,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  cal_field_counter_if.slave  bus
);

  localparam int CW = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1;
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_VAL);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_e;

  // state
  logic             inc_s1_q, inc_s2_q, inc_e_q;
  logic             dec_s1_q, dec_s2_q, dec_e_q;
  logic             inc_s1_d, inc_s2_d, inc_e_d;
  logic             dec_s1_d, dec_s2_d, dec_e_d;
  state_e           state_q, state_d;
  logic             dir_q, dir_d;          // 1 = increment
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_inc_q, pend_inc_d;
  logic             pend_dec_q, pend_dec_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  // combinational helpers
  logic             rise_inc, rise_dec, held;
  logic             btn_step, btn_up;
  logic [WIDTH:0]   lim_diff, ld_diff;
  logic [WIDTH-1:0] lim_eff;
  logic             load_ok;
  logic             at_top, at_bot, pend_any;
  logic [WIDTH-1:0] up_next, dn_next;

  // Synchronisers, edge detect, button FSM and value update priority
  always_comb begin
    inc_s1_d = bus.inc_btn;
    inc_s2_d = inc_s1_q;
    inc_e_d  = inc_s2_q;
    dec_s1_d = bus.dec_btn;
    dec_s2_d = dec_s1_q;
    dec_e_d  = dec_s2_q;

    rise_inc = inc_s2_q & ~inc_e_q;
    rise_dec = dec_s2_q & ~dec_e_q;
    held     = dir_q ? inc_s2_q : dec_s2_q;

    // button FSM: produces at most one step per cycle
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    btn_step = 1'b0;
    btn_up   = dir_q;
    case (state_q)
      IDLE: begin
        // a rise while the other button is held is ambiguous: no step
        if (rise_inc && !dec_s2_q) begin
          btn_step = 1'b1; btn_up = 1'b1; dir_d = 1'b1;
          cnt_d = '0; state_d = WAIT;
        end else if (rise_dec && !inc_s2_q) begin
          btn_step = 1'b1; btn_up = 1'b0; dir_d = 1'b0;
          cnt_d = '0; state_d = WAIT;
        end
      end
      WAIT: begin
        if (!held) begin
          state_d = IDLE; cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          btn_step = 1'b1; cnt_d = '0; state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!held) begin
          state_d = IDLE; cnt_d = '0;
        end else if (cnt_q == REP_LAST) begin
          btn_step = 1'b1; cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE; cnt_d = '0;
      end
    endcase

    // Bound checks work on offsets from MIN_VAL; the extra MSB flags
    // "below MIN_VAL" without a separate magnitude compare.
    lim_diff = {1'b0, bus.limit} - {1'b0, MIN_W};
    lim_eff  = lim_diff[WIDTH] ? MIN_W : (lim_diff[WIDTH-1:0] + MIN_W);
    ld_diff  = {1'b0, bus.load_val} - {1'b0, MIN_W};
    load_ok  = !ld_diff[WIDTH] && (ld_diff[WIDTH-1:0] <= (lim_eff - MIN_W));

    at_top   = (value_q == lim_eff);
    at_bot   = (value_q == MIN_W);
    up_next  = at_top ? MIN_W : (value_q + WIDTH'(1));
    dn_next  = at_bot ? lim_eff : (value_q - WIDTH'(1));
    pend_any = pend_inc_q | pend_dec_q;

    value_d    = value_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    pend_inc_d = pend_inc_q;
    pend_dec_d = pend_dec_q;

    if (bus.load) begin
      value_d    = load_ok ? bus.load_val : MIN_W;
      pend_inc_d = 1'b0;
      pend_dec_d = 1'b0;
    end else if (value_q > lim_eff) begin
      value_d = lim_eff;
      if (btn_step && !pend_any) begin
        pend_inc_d = btn_up;
        pend_dec_d = !btn_up;
      end
    end else if (bus.tick) begin
      value_d = up_next;
      carry_d = at_top;
      if (btn_step && !pend_any) begin
        pend_inc_d = btn_up;
        pend_dec_d = !btn_up;
      end
    end else if (pend_any) begin
      // a button step colliding with the pending one is dropped
      if (pend_inc_q) begin
        value_d = up_next; carry_d = at_top;
      end else begin
        value_d = dn_next; borrow_d = at_bot;
      end
      pend_inc_d = 1'b0;
      pend_dec_d = 1'b0;
    end else if (btn_step) begin
      if (btn_up) begin
        value_d = up_next; carry_d = at_top;
      end else begin
        value_d = dn_next; borrow_d = at_bot;
      end
    end
  end

  // All state registers; reset returns synchronisers to 0 so a held
  // button needs a fresh rising edge afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_s1_q   <= 1'b0; inc_s2_q <= 1'b0; inc_e_q <= 1'b0;
      dec_s1_q   <= 1'b0; dec_s2_q <= 1'b0; dec_e_q <= 1'b0;
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      pend_inc_q <= 1'b0;
      pend_dec_q <= 1'b0;
      value_q    <= MIN_W;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
    end else begin
      inc_s1_q   <= inc_s1_d; inc_s2_q <= inc_s2_d; inc_e_q <= inc_e_d;
      dec_s1_q   <= dec_s1_d; dec_s2_q <= dec_s2_d; dec_e_q <= dec_e_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      pend_inc_q <= pend_inc_d;
      pend_dec_q <= pend_dec_d;
      value_q    <= value_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
    end
  end

  assign bus.value  = value_q;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_cal_field_counter.sv
// Directed bench: date-style instance (MIN=1) driven from a vector table
// plus hand sequences for button timing, plus a weekday instance (MIN=0).
module tb_cal_field_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  cal_field_counter_if #(.WIDTH(5)) a_if ();
  cal_field_counter_if #(.WIDTH(5)) w_if ();

  cal_field_counter #(.WIDTH(5), .MIN_VAL(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  cal_field_counter #(.WIDTH(5), .MIN_VAL(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_w (
    .clk(clk), .reset(reset), .bus(w_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [4:0] ldv;
    logic [4:0] lim;
    logic       tk;
    logic [4:0] ev;
    logic       ec;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  // one clock: inputs set at negedge, sampled at posedge, checked at negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input int ev, input int ec, input int eb);
    chk({nm, " value"},  int'(a_if.value),  ev);
    chk({nm, " carry"},  int'(a_if.carry),  ec);
    chk({nm, " borrow"}, int'(a_if.borrow), eb);
  endtask

  task automatic load_a(input int v);
    a_if.load = 1'b1; a_if.load_val = 5'(v);
    cyc();
    a_if.load = 1'b0;
  endtask

  initial begin
    int exp_v;
    int ncarry;

    a_if.tick = 0; a_if.inc_btn = 0; a_if.dec_btn = 0; a_if.load = 0;
    a_if.load_val = 0; a_if.limit = 5'd31;
    w_if.tick = 0; w_if.inc_btn = 0; w_if.dec_btn = 0; w_if.load = 0;
    w_if.load_val = 0; w_if.limit = 5'd6;

    // value, carry, borrow after each row's edge (limit < MIN acts as MIN)
    vecs.push_back('{0,  0, 31, 1,  2, 0, 0});
    vecs.push_back('{0,  0, 31, 1,  3, 0, 0});
    vecs.push_back('{0,  0, 31, 1,  4, 0, 0});
    vecs.push_back('{1, 15, 31, 0, 15, 0, 0});
    vecs.push_back('{1,  0, 31, 0,  1, 0, 0});
    vecs.push_back('{1, 31, 31, 0, 31, 0, 0});
    vecs.push_back('{0,  0, 31, 1,  1, 1, 0});
    vecs.push_back('{0,  0, 31, 0,  1, 0, 0});
    vecs.push_back('{1, 31, 31, 0, 31, 0, 0});
    vecs.push_back('{0,  0, 28, 0, 28, 0, 0});
    vecs.push_back('{0,  0, 28, 1,  1, 1, 0});
    vecs.push_back('{1, 30, 28, 0,  1, 0, 0});
    vecs.push_back('{1, 20, 28, 1, 20, 0, 0});
    vecs.push_back('{1, 28, 28, 1, 28, 0, 0});
    vecs.push_back('{0,  0, 28, 1,  1, 1, 0});
    vecs.push_back('{0,  0,  0, 1,  1, 1, 0});
    vecs.push_back('{1,  9,  1, 1,  1, 0, 0});
    vecs.push_back('{0,  0, 31, 0,  1, 0, 0});

    // reset state
    repeat (2) cyc();
    chk_a("reset", 1, 0, 0);
    chk("reset weekday value", int'(w_if.value), 0);
    reset = 1'b1;
    cyc();
    chk_a("post-reset idle", 1, 0, 0);

    // table
    foreach (vecs[i]) begin
      a_if.load = vecs[i].ld; a_if.load_val = vecs[i].ldv;
      a_if.limit = vecs[i].lim; a_if.tick = vecs[i].tk;
      cyc();
      chk_a($sformatf("vec%0d", i), int'(vecs[i].ev), int'(vecs[i].ec), int'(vecs[i].eb));
    end
    a_if.load = 0; a_if.tick = 0; a_if.limit = 5'd31;
    cyc();

    // asynchronous reset mid-operation, then 3 ticks
    load_a(10);
    chk_a("pre-reset load", 10, 0, 0);
    a_if.tick = 1'b1;
    #2 reset = 1'b0;
    #1 chk_a("async reset", 1, 0, 0);
    chk("async reset weekday", int'(w_if.value), 0);
    a_if.tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    a_if.tick = 1'b1;
    repeat (3) cyc();
    a_if.tick = 1'b0;
    chk_a("3 ticks after reset", 4, 0, 0);

    // weekday: 7 ticks from 0 wrap back to 0 with one carry
    ncarry = 0;
    w_if.tick = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      ncarry += int'(w_if.carry);
      chk($sformatf("weekday tick%0d value", k), int'(w_if.value), (k + 1) % 7);
    end
    w_if.tick = 1'b0;
    chk("weekday carry count", ncarry, 1);

    // hold inc for 20 samples: steps at N+2, N+10, N+14, N+18
    cyc();
    load_a(5);
    a_if.inc_btn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      exp_v = 5 + int'(k >= 2) + int'(k >= 10) + int'(k >= 14) + int'(k >= 18);
      chk($sformatf("hold inc N+%0d", k), int'(a_if.value), exp_v);
      if (k == 19) a_if.inc_btn = 1'b0;
    end

    // both buttons pressed together: no step
    load_a(7);
    a_if.inc_btn = 1'b1; a_if.dec_btn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("both held %0d", k), int'(a_if.value), 7);
    end
    a_if.inc_btn = 1'b0; a_if.dec_btn = 1'b0;
    repeat (4) cyc();

    // dec at MIN wraps to limit with a single borrow pulse
    load_a(1);
    a_if.dec_btn = 1'b1;
    cyc();
    a_if.dec_btn = 1'b0;
    cyc();
    chk_a("dec N+1", 1, 0, 0);
    cyc();
    chk_a("dec wrap N+2", 31, 0, 1);
    cyc();
    chk_a("dec wrap N+3", 31, 0, 0);
    repeat (3) cyc();

    // tick colliding with inc step: tick now, pending step next edge
    load_a(5);
    a_if.inc_btn = 1'b1;
    cyc();
    a_if.inc_btn = 1'b0;
    cyc();
    a_if.tick = 1'b1;
    cyc();
    a_if.tick = 1'b0;
    chk_a("tick+inc edge", 6, 0, 0);
    cyc();
    chk_a("tick+inc pending", 7, 0, 0);
    repeat (3) cyc();

    // tick colliding with dec step
    load_a(5);
    a_if.dec_btn = 1'b1;
    cyc();
    a_if.dec_btn = 1'b0;
    cyc();
    a_if.tick = 1'b1;
    cyc();
    a_if.tick = 1'b0;
    chk_a("tick+dec edge", 6, 0, 0);
    cyc();
    chk_a("tick+dec pending", 5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
